gene_sweep_driver: RTL and testbench

- Stimulus side of the gene-network fixed-point check; drives the network rather than observing it.
- For each initial 8-gene state in a programmable range, it loads the state and iterates the external Boolean update function one step per clock.
- It stops on a fixed point (next state == current state) or a step limit, then emits one result record per initial state over a valid/ready handshake.
- It exports the current state and initial value so a fixed-point checker can monitor the same trajectory.

---
 rtl/gene_sweep_driver.sv | 174 +++++++++++++++++
 tb/tb_gene_sweep_driver.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gene_sweep_driver.sv
// Gene-network sweep driver: walks initial states lo..hi (with 8-bit wrap),
// iterates the external update function until a fixed point or the step
// limit, and hands one result record per initial state to a valid/ready sink.
module gene_sweep_driver #(
  parameter int unsigned MAX_STEPS = 64,
  parameter int unsigned STEP_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        sweep_lo,
  input  logic [7:0]        sweep_hi,
  output logic [7:0]        x,
  input  logic [7:0]        nx_in,
  output logic [7:0]        init_val,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [7:0]        res_init,
  output logic [7:0]        res_state,
  output logic [STEP_W-1:0] res_steps,
  output logic              res_found,
  output logic [8:0]        fp_count,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_REPORT,
    S_FIN
  } state_e;

  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

  state_e            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        cur_q, cur_d;
  logic [7:0]        x_q, x_d;
  logic [7:0]        init_q, init_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [7:0]        rec_init_q, rec_init_d;
  logic [7:0]        rec_state_q, rec_state_d;
  logic [STEP_W-1:0] rec_steps_q, rec_steps_d;
  logic              rec_found_q, rec_found_d;
  logic [8:0]        fp_q, fp_d;

  logic is_fixed;
  logic at_limit;
  logic last_init;

  assign is_fixed  = (nx_in == x_q);
  assign at_limit  = (steps_q == STEP_LIMIT);
  assign last_init = (cur_q == hi_q);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: abort overrides every transition
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   if (start) state_d = S_LOAD;
        S_LOAD:   state_d = S_RUN;
        S_RUN:    if (is_fixed || at_limit) state_d = S_REPORT;
        S_REPORT: if (res_ready) state_d = last_init ? S_FIN : S_LOAD;
        S_FIN:    state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs decoded from the registered state
  always_comb begin
    busy      = (state_q != S_IDLE);
    res_valid = (state_q == S_REPORT);
    done      = (state_q == S_FIN);
  end

  // Datapath next-state; abort freezes all data so fp_count keeps its partial value
  always_comb begin
    hi_d        = hi_q;
    cur_d       = cur_q;
    x_d         = x_q;
    init_d      = init_q;
    steps_d     = steps_q;
    rec_init_d  = rec_init_q;
    rec_state_d = rec_state_q;
    rec_steps_d = rec_steps_q;
    rec_found_d = rec_found_q;
    fp_d        = fp_q;
    if (!abort) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            hi_d  = sweep_hi;
            cur_d = sweep_lo;
            fp_d  = '0;
          end
        end
        S_LOAD: begin
          x_d     = cur_q;
          init_d  = cur_q;
          steps_d = '0;
        end
        S_RUN: begin
          if (is_fixed) begin
            rec_init_d  = init_q;
            rec_state_d = x_q;
            rec_steps_d = steps_q;
            rec_found_d = 1'b1;
            fp_d        = fp_q + 9'd1;
          end else if (at_limit) begin
            rec_init_d  = init_q;
            rec_state_d = x_q;
            rec_steps_d = steps_q;
            rec_found_d = 1'b0;
          end else begin
            x_d     = nx_in;
            steps_d = steps_q + STEP_W'(1);
          end
        end
        S_REPORT: begin
          if (res_ready && !last_init) cur_d = cur_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q        <= '0;
      cur_q       <= '0;
      x_q         <= '0;
      init_q      <= '0;
      steps_q     <= '0;
      rec_init_q  <= '0;
      rec_state_q <= '0;
      rec_steps_q <= '0;
      rec_found_q <= 1'b0;
      fp_q        <= '0;
    end else begin
      hi_q        <= hi_d;
      cur_q       <= cur_d;
      x_q         <= x_d;
      init_q      <= init_d;
      steps_q     <= steps_d;
      rec_init_q  <= rec_init_d;
      rec_state_q <= rec_state_d;
      rec_steps_q <= rec_steps_d;
      rec_found_q <= rec_found_d;
      fp_q        <= fp_d;
    end
  end

  assign x         = x_q;
  assign init_val  = init_q;
  assign res_init  = rec_init_q;
  assign res_state = rec_state_q;
  assign res_steps = rec_steps_q;
  assign res_found = rec_found_q;
  assign fp_count  = fp_q;

endmodule

// File: tb/tb_gene_sweep_driver.sv
// Bench for gene_sweep_driver: a trajectory model predicts every record,
// one negedge process compares records and fp_count, directed tests pin literals.
module tb_gene_sweep_driver;

  localparam int unsigned MAXS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       res_ready = 1'b1;
  logic [7:0] sweep_lo = '0;
  logic [7:0] sweep_hi = '0;
  logic [7:0] nx_in;
  logic [7:0] x, init_val, res_init, res_state;
  logic [7:0] res_steps;
  logic       busy, res_valid, res_found, done;
  logic [8:0] fp_count;

  int rule = 0;

  typedef struct packed {
    logic [7:0] init;
    logic [7:0] state;
    logic [7:0] steps;
    logic       found;
  } rec_t;

  rec_t exp_q[$];
  rec_t last_rec;
  int   checks = 0;
  int   failures = 0;
  int   rec_cnt = 0;
  int   done_cnt = 0;
  int   exp_fp = 0;

  gene_sweep_driver #(.MAX_STEPS(MAXS), .STEP_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .sweep_lo(sweep_lo), .sweep_hi(sweep_hi),
    .x(x), .nx_in(nx_in), .init_val(init_val), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_init(res_init), .res_state(res_state), .res_steps(res_steps),
    .res_found(res_found), .fp_count(fp_count), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rule_f(input int r, input logic [7:0] s);
    case (r)
      0:       return s;
      1:       return s >> 1;
      2:       return ~s;
      default: return {s[6:0], s[7]};
    endcase
  endfunction

  always_comb nx_in = rule_f(rule, x);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Expected records: follow each trajectory with plain iteration
  task automatic model_sweep(input logic [7:0] lo, input logic [7:0] hi);
    logic [7:0] v, s;
    int unsigned n;
    rec_t r;
    exp_fp = 0;
    v = lo;
    forever begin
      s = v;
      n = 0;
      while (rule_f(rule, s) != s && n < MAXS) begin
        s = rule_f(rule, s);
        n++;
      end
      r.init  = v;
      r.state = s;
      r.steps = 8'(n);
      r.found = (rule_f(rule, s) == s);
      exp_q.push_back(r);
      if (r.found) exp_fp++;
      if (v == hi) break;
      v = v + 8'd1;
    end
  endtask

  // Compare process: every valid cycle against the head of the expected queue
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rec_unexpected actual_init=%0h required=none", res_init);
        end else begin
          chk("rec_init", res_init, exp_q[0].init);
          chk("rec_state", res_state, exp_q[0].state);
          chk("rec_steps", res_steps, exp_q[0].steps);
          chk("rec_found", res_found, exp_q[0].found);
          if (res_ready) begin
            last_rec = exp_q.pop_front();
            rec_cnt++;
          end
        end
      end
    end
  end

  task automatic start_sweep(input int r, input logic [7:0] lo, input logic [7:0] hi);
    @(posedge clk); #1;
    rule = r;
    sweep_lo = lo;
    sweep_hi = hi;
    model_sweep(lo, hi);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    bit got;
    cyc = 0;
    got = 0;
    while (cyc < budget && !got) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=%0d cycles required=done pulse", cyc);
    end else begin
      chk("queue_drained", exp_q.size(), 0);
      chk("fp_count_model", fp_count, exp_fp);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_after_fin", busy, 0);
    end
  endtask

  task automatic wait_valid(input int budget);
    int c;
    c = 0;
    while (c < budget && !res_valid) begin
      @(negedge clk);
      c++;
    end
    if (!res_valid) begin
      checks++;
      failures++;
      $display("FAIL valid_timeout actual=%0d cycles required=res_valid", c);
    end
  endtask

  task automatic check_zero();
    chk("rst_x", x, 0);
    chk("rst_init_val", init_val, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_init", res_init, 0);
    chk("rst_res_state", res_state, 0);
    chk("rst_res_steps", res_steps, 0);
    chk("rst_res_found", res_found, 0);
    chk("rst_fp_count", fp_count, 0);
    chk("rst_done", done, 0);
  endtask

  initial begin
    int cyc, r0, d0, c;

    // Reset state
    #1 rst = 1'b1;
    #10 check_zero();
    @(posedge clk); #1 rst = 1'b0;

    // Identity rule, 4 fixed points, 12 cycles LOAD..FIN
    start_sweep(0, 8'h10, 8'h13);
    wait_done(200, cyc);
    chk("load_to_fin_cycles", cyc - 1, 12);
    chk("ident_fp_count", fp_count, 4);
    chk("ident_last_init", last_rec.init, 8'h13);
    chk("ident_last_steps", last_rec.steps, 0);

    // Shift rule trajectory 05,02,01,00
    start_sweep(1, 8'h05, 8'h05);
    @(negedge clk);
    for (int unsigned i = 0; i < 4; i++) begin
      logic [7:0] seq [4];
      seq[0] = 8'h05; seq[1] = 8'h02; seq[2] = 8'h01; seq[3] = 8'h00;
      @(negedge clk);
      chk("shift_x_seq", x, seq[i]);
    end
    wait_done(50, cyc);
    chk("shift_state", last_rec.state, 8'h00);
    chk("shift_steps", last_rec.steps, 3);
    chk("shift_found", last_rec.found, 1);

    // Invert rule times out at the step limit
    start_sweep(2, 8'hA5, 8'hA5);
    wait_done(100, cyc);
    chk("inv_found", last_rec.found, 0);
    chk("inv_steps", last_rec.steps, 16);
    chk("inv_state", last_rec.state, 8'hA5);
    chk("inv_fp_count", fp_count, 0);

    // Rotate rule over the full range
    r0 = rec_cnt; d0 = done_cnt;
    start_sweep(3, 8'h00, 8'hFF);
    wait_done(10000, cyc);
    chk("rot_fp_count", fp_count, 2);
    chk("rot_records", rec_cnt - r0, 256);
    chk("rot_done_pulses", done_cnt - d0, 1);

    // Backpressure: record held stable while ready is low
    @(posedge clk); #1 res_ready = 1'b0;
    r0 = rec_cnt;
    start_sweep(0, 8'h42, 8'h42);
    wait_valid(20);
    for (int unsigned i = 0; i < 5; i++) begin
      chk("bp_valid", res_valid, 1);
      chk("bp_init", res_init, 8'h42);
      chk("bp_state", res_state, 8'h42);
      chk("bp_steps", res_steps, 0);
      chk("bp_found", res_found, 1);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    wait_done(20, cyc);
    chk("bp_single_transfer", rec_cnt - r0, 1);

    // Wrap through 255 -> 0
    r0 = rec_cnt;
    start_sweep(0, 8'hFE, 8'h01);
    wait_done(100, cyc);
    chk("wrap_records", rec_cnt - r0, 4);
    chk("wrap_last_init", last_rec.init, 8'h01);
    chk("wrap_fp_count", fp_count, 4);

    // Abort during RUN of the second initial state
    r0 = rec_cnt; d0 = done_cnt;
    start_sweep(1, 8'hFE, 8'h01);
    c = 0;
    while (c < 100 && init_val != 8'hFF) begin
      @(negedge clk);
      c++;
    end
    chk("abort_reached_2nd", init_val, 8'hFF);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", res_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_fp_partial", fp_count, 1);
    exp_q.delete();
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_records", rec_cnt - r0, 1);

    // Asynchronous reset while a record waits in REPORT
    @(posedge clk); #1 res_ready = 1'b0;
    start_sweep(0, 8'h33, 8'h33);
    wait_valid(20);
    #3 rst = 1'b1;
    #1 check_zero();
    @(posedge clk); #1;
    rst = 1'b0;
    res_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
